ddr3_startup_sequencer: RTL and testbench
=========================================

Name: ddr3_startup_sequencer

Overview:
- Consumes the global startup signals (global set/reset, global tristate, restore pulse) and the PLL lock.
- Drives the DDR3 power-up sequence: RESET# hold, then CKE wait, then controller reset release.
- Sits between the clocking/startup fabric and the DDR3 controller top; it is the consumer end of the startup-globals interface.
- Gives the controller a single, deterministic, lock-qualified release point.

Parameters:
- LOCK_STABLE_CYCLES, 16: consecutive cycles i_pll_locked must be high before sequencing starts (>=1).
- RESET_HOLD_CYCLES, 40000: cycles o_ddr3_reset_n is held low (200 us at 200 MHz; >=1).
- CKE_WAIT_CYCLES, 100000: cycles from RESET# high to CKE high (500 us at 200 MHz; >=1).
- CNT_WIDTH, 20: counter width; must hold max(param)-1.

Ports:
- i_controller_clk  input  1  sole clock
- i_rst_n  input  1  synchronous active-low reset
- i_pll_locked  input  1  PLL lock, already synchronous to i_controller_clk
- i_gsr  input  1  global set/reset, active high
- i_gts  input  1  global tristate, active high
- i_grestore  input  1  restore request, level; rising edge detected internally
- o_ddr3_reset_n  output  1  DDR3 RESET#
- o_ddr3_cke  output  1  DDR3 CKE
- o_ddr3_oe  output  1  DDR3 pad output enable
- o_ctrl_rst_n  output  1  controller reset, active low
- o_ready  output  1  sequence complete
- o_state  output  3  current state encoding, for debug

Behaviour:
- All inputs and outputs are sampled/updated on the rising edge of i_controller_clk. All outputs are registered.
- Reset (i_rst_n=0 at an edge):
  - state=IDLE, counter=0, restore edge register=0.
  - o_ddr3_reset_n=0, o_ddr3_cke=0, o_ddr3_oe=0, o_ctrl_rst_n=0, o_ready=0, o_state=0.
  - Reset asserted mid-sequence aborts the sequence immediately with the same values.
- "Go" condition: i_pll_locked=1 and i_gsr=0.
- States and transitions:
  - IDLE (0): wait for go. On go -> LOCK_WAIT, counter=0.
  - LOCK_WAIT (1): counter increments each cycle go holds. When counter == LOCK_STABLE_CYCLES-1 and go still holds -> RST_HOLD, counter=0. If go drops, counter clears and state stays LOCK_WAIT (restart of stability window).
  - RST_HOLD (2): o_ddr3_reset_n=0, o_ddr3_cke=0. At counter == RESET_HOLD_CYCLES-1 -> CKE_WAIT, counter=0.
  - CKE_WAIT (3): o_ddr3_reset_n=1, o_ddr3_cke=0. At counter == CKE_WAIT_CYCLES-1 -> RUN, counter=0.
  - RUN (4): o_ddr3_reset_n=1, o_ddr3_cke=1, o_ctrl_rst_n=1, o_ready=1.
- Dwell times: each timed state is occupied for exactly N cycles, from the entry edge to the exit edge, where N is its parameter. Outputs reflect the new state on the edge of transition.
- Lock loss or i_gsr=1 in RST_HOLD, CKE_WAIT or RUN -> IDLE next edge with all reset values. Asserting i_gsr in LOCK_WAIT only restarts the stability window.
- i_grestore rising edge (registered version 0, current 1) in RUN -> RST_HOLD, counter=0. The same edge in any other state is ignored (no queuing).
- Simultaneous lock loss and restore edge: lock loss wins (-> IDLE).
- o_ddr3_oe = ~i_gts registered, but forced 0 while state is IDLE.
- Counter never wraps: it is cleared on every state change and compared with ==.
- Encodings 5–7 are illegal and recover to IDLE next edge.

Test Plan:
- Params LOCK=4, HOLD=8, CKE=6; i_rst_n released at cycle 0 with lock=1, gsr=0 -> IDLE at cycle 1, LOCK_WAIT cycles 2–5, RST_HOLD cycles 6–13, reset_n rises at cycle 14, cke/ctrl_rst_n/ready rise at cycle 20.
- Same setup, lock drops for 1 cycle at LOCK_WAIT count 2 -> window restarts; RST_HOLD entry delayed by 3 cycles.
- In CKE_WAIT, drop i_pll_locked -> next edge: state=0, reset_n=0, cke=0, oe=0; re-lock repeats the full sequence with identical timing.
- In RUN, pulse i_grestore high for 3 cycles -> exactly one re-entry into RST_HOLD; ready=0 for 14 cycles, then returns to 1.
- i_gsr=1 while in RUN together with a restore edge -> IDLE; no RST_HOLD entry.
- Assert i_rst_n=0 for 1 cycle during RST_HOLD -> all outputs at reset values next edge; sequence restarts from IDLE.

Source files
------------

// File: rtl/ddr3_startup_sequencer.sv
// DDR3 power-up sequencer: lock qualification, RESET# hold, CKE wait,
// then a single registered release point for the controller.
module ddr3_startup_sequencer #(
   parameter int unsigned LOCK_STABLE_CYCLES = 16,
   parameter int unsigned RESET_HOLD_CYCLES  = 40000,
   parameter int unsigned CKE_WAIT_CYCLES    = 100000,
   parameter int unsigned CNT_WIDTH          = 20
) (
   input  logic       i_controller_clk,
   input  logic       i_rst_n,
   input  logic       i_pll_locked,
   input  logic       i_gsr,
   input  logic       i_gts,
   input  logic       i_grestore,
   output logic       o_ddr3_reset_n,
   output logic       o_ddr3_cke,
   output logic       o_ddr3_oe,
   output logic       o_ctrl_rst_n,
   output logic       o_ready,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOCK_WAIT = 3'd1,
      S_RST_HOLD  = 3'd2,
      S_CKE_WAIT  = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CKE_LAST  = CNT_WIDTH'(CKE_WAIT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 restore_q, restore_d;
   logic                 reset_n_q, reset_n_d;
   logic                 run_q, run_d;
   logic                 oe_q, oe_d;
   logic                 go;
   logic                 restore_edge;

   assign go           = i_pll_locked & ~i_gsr;
   assign restore_edge = i_grestore & ~restore_q;

   // Next-state, dwell counter and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      restore_d = i_grestore;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (go) state_d = S_LOCK_WAIT;
         end
         S_LOCK_WAIT: begin
            if (!go) begin
               cnt_d = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = S_RST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RST_HOLD: begin
            if (!go) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = S_CKE_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_CKE_WAIT: begin
            if (!go) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CKE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!go) begin
               state_d = S_IDLE;
            end else if (restore_edge) begin
               state_d = S_RST_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      reset_n_d = (state_d == S_CKE_WAIT) || (state_d == S_RUN);
      run_d     = (state_d == S_RUN);
      oe_d      = ~i_gts && (state_d != S_IDLE);
   end

   // State, counter, restore edge register and output flops
   always_ff @(posedge i_controller_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         restore_q <= 1'b0;
         reset_n_q <= 1'b0;
         run_q     <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         restore_q <= restore_d;
         reset_n_q <= reset_n_d;
         run_q     <= run_d;
         oe_q      <= oe_d;
      end
   end

   assign o_ddr3_reset_n = reset_n_q;
   assign o_ddr3_cke     = run_q;
   assign o_ctrl_rst_n   = run_q;
   assign o_ready        = run_q;
   assign o_ddr3_oe      = oe_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_ddr3_startup_sequencer.sv
// Bench for ddr3_startup_sequencer: timeline model compared every cycle
// plus directed scenarios with hand-computed cycle counts.
module tb_ddr3_startup_sequencer;

   localparam int L = 4;
   localparam int H = 8;
   localparam int C = 6;

   logic       clk = 1'b0;
   logic       rst_n, lock, gsr, gts, grestore;
   logic       ddr3_reset_n, ddr3_cke, ddr3_oe, ctrl_rst_n, ready;
   logic [2:0] state;

   int checks = 0;
   int failures = 0;

   ddr3_startup_sequencer #(
      .LOCK_STABLE_CYCLES(L),
      .RESET_HOLD_CYCLES (H),
      .CKE_WAIT_CYCLES   (C),
      .CNT_WIDTH         (20)
   ) dut (
      .i_controller_clk(clk),
      .i_rst_n         (rst_n),
      .i_pll_locked    (lock),
      .i_gsr           (gsr),
      .i_gts           (gts),
      .i_grestore      (grestore),
      .o_ddr3_reset_n  (ddr3_reset_n),
      .o_ddr3_cke      (ddr3_cke),
      .o_ddr3_oe       (ddr3_oe),
      .o_ctrl_rst_n    (ctrl_rst_n),
      .o_ready         (ready),
      .o_state         (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: m_e counts cycles since the lock window began
   bit m_ok = 0;
   bit m_active = 0;
   int m_e = 0;
   bit m_prev = 0;
   bit m_oe = 0;

   always @(posedge clk) begin
      bit g;
      bit redge;
      g = lock && !gsr;
      redge = grestore && !m_prev;
      if (!rst_n) begin
         m_active = 0;
         m_e = 0;
         m_prev = 0;
      end else begin
         if (!m_active) begin
            if (g) begin
               m_active = 1;
               m_e = 0;
            end
         end else if (m_e < L) begin
            if (!g) m_e = 0;
            else m_e++;
         end else begin
            if (!g) m_active = 0;
            else if (m_e >= L + H + C) begin
               if (redge) m_e = L;
            end else m_e++;
         end
         m_prev = grestore;
      end
      m_oe = rst_n && !gts && m_active;
      m_ok = 1;
   end

   function automatic int m_state();
      if (!m_active) return 0;
      if (m_e < L) return 1;
      if (m_e < L + H) return 2;
      if (m_e < L + H + C) return 3;
      return 4;
   endfunction

   always @(negedge clk) begin
      if (m_ok) begin
         int s;
         s = m_state();
         chk("mdl_state", int'(state), s);
         chk("mdl_reset_n", int'(ddr3_reset_n), int'(s >= 3));
         chk("mdl_cke", int'(ddr3_cke), int'(s == 4));
         chk("mdl_ctrl_rst_n", int'(ctrl_rst_n), int'(s == 4));
         chk("mdl_ready", int'(ready), int'(s == 4));
         chk("mdl_oe", int'(ddr3_oe), int'(m_oe));
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_state(input int s, input int bound, output int n);
      n = 0;
      while (int'(state) != s && n < bound) begin
         step(1);
         n++;
      end
      chk($sformatf("wait_state%0d", s), int'(state), s);
   endtask

   initial begin
      int n;
      int n0;
      int entries;
      int zeros;
      logic [2:0] prev;
      rst_n = 0;
      lock = 1;
      gsr = 0;
      gts = 0;
      grestore = 0;
      step(2);
      chk("rst_state", int'(state), 0);
      chk("rst_reset_n", int'(ddr3_reset_n), 0);
      chk("rst_cke", int'(ddr3_cke), 0);
      chk("rst_oe", int'(ddr3_oe), 0);
      chk("rst_ctrl", int'(ctrl_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      rst_n = 1;

      // basic timing: LOCK_WAIT 2-5, RST_HOLD 6-13, CKE_WAIT 14-19, RUN 20
      step(1);
      chk("c2_state", int'(state), 1);
      step(4);
      chk("c6_state", int'(state), 2);
      step(7);
      chk("c13_state", int'(state), 2);
      chk("c13_reset_n", int'(ddr3_reset_n), 0);
      step(1);
      chk("c14_state", int'(state), 3);
      chk("c14_reset_n", int'(ddr3_reset_n), 1);
      chk("c14_cke", int'(ddr3_cke), 0);
      step(5);
      chk("c19_ready", int'(ready), 0);
      step(1);
      chk("c20_state", int'(state), 4);
      chk("c20_cke", int'(ddr3_cke), 1);
      chk("c20_ctrl", int'(ctrl_rst_n), 1);
      chk("c20_ready", int'(ready), 1);
      chk("c20_oe", int'(ddr3_oe), 1);

      // 3-cycle restore pulse: one re-entry, ready low for 14 cycles
      grestore = 1;
      step(1);
      chk("rest_state", int'(state), 2);
      zeros = (ready == 1'b0) ? 1 : 0;
      entries = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) grestore = 0;
         prev = state;
         step(1);
         if (ready == 1'b0) zeros++;
         if (state == 3'd2 && prev != 3'd2) entries++;
      end
      chk("rest_ready_low", zeros, 14);
      chk("rest_entries", entries, 1);
      chk("rest_back_run", int'(state), 4);

      // gsr with restore edge in RUN: gsr wins
      gsr = 1;
      grestore = 1;
      step(1);
      chk("gsr_state", int'(state), 0);
      chk("gsr_oe", int'(ddr3_oe), 0);
      n0 = 0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (state == 3'd2) n0++;
      end
      chk("gsr_no_hold", n0, 0);
      gsr = 0;
      grestore = 0;
      step(1);
      chk("relock_state", int'(state), 1);

      // lock glitch at count 2 delays RST_HOLD entry by 3 cycles
      step(2);
      lock = 0;
      step(1);
      chk("glitch_state", int'(state), 1);
      lock = 1;
      wait_state(2, 10, n);
      chk("glitch_delay", n, 4);

      // lock loss in CKE_WAIT, then identical re-sequence
      wait_state(3, 20, n);
      step(2);
      lock = 0;
      step(1);
      chk("loss_state", int'(state), 0);
      chk("loss_reset_n", int'(ddr3_reset_n), 0);
      chk("loss_cke", int'(ddr3_cke), 0);
      chk("loss_oe", int'(ddr3_oe), 0);
      lock = 1;
      wait_state(3, 30, n);
      chk("reseq_to_cke", n, 1 + L + H);
      wait_state(4, 30, n);
      chk("reseq_to_run", n, C);

      // gts gates oe
      gts = 1;
      step(1);
      chk("gts_oe0", int'(ddr3_oe), 0);
      gts = 0;
      step(1);
      chk("gts_oe1", int'(ddr3_oe), 1);

      // reset pulse during RST_HOLD
      grestore = 1;
      step(1);
      chk("rh_state", int'(state), 2);
      grestore = 0;
      step(3);
      rst_n = 0;
      step(1);
      chk("rp_state", int'(state), 0);
      chk("rp_reset_n", int'(ddr3_reset_n), 0);
      chk("rp_oe", int'(ddr3_oe), 0);
      chk("rp_ready", int'(ready), 0);
      rst_n = 1;
      step(1);
      chk("rp_restart", int'(state), 1);
      wait_state(4, 40, n);
      chk("rp_to_run", n, L + H + C);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
